// File: rtl/rgmii_pkg.sv
// Shared types and constants for the Ethernet transmit path.
package rgmii_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        GAP
    } eth_tx_arb_state_t;

    localparam int IFG_BYTES = 12;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: first requester after last_grant wins.
module rr_arbiter #(
    parameter  int NUM_SRC = 4,
    localparam int GW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic [GW-1:0]      grant,
    output logic               any_req
);

    // Scan from farthest to nearest so the nearest requester is written last.
    always_comb begin
        grant = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            if (req[(int'(last_grant) + i) % NUM_SRC])
                grant = GW'((int'(last_grant) + i) % NUM_SRC);
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one Ethernet TX stream
// between several AXI-Stream sources, with length checking and IFG.
module eth_tx_arbiter
    import rgmii_pkg::*;
#(
    parameter  int NUM_SRC       = 4,
    parameter  int DATA_WIDTH    = 8,
    parameter  int PAYLOAD_WIDTH = 11,
    parameter  int IFG_CYCLES    = IFG_BYTES,
    localparam int GW            = $clog2(NUM_SRC)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_SRC-1:0]               s_tvalid_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_tdata_i,
    input  logic [NUM_SRC-1:0]               s_tlast_i,
    output logic [NUM_SRC-1:0]               s_tready_o,
    input  logic [NUM_SRC*PAYLOAD_WIDTH-1:0] s_payload_bytes_i,
    output logic                             m_tvalid_o,
    output logic [DATA_WIDTH-1:0]            m_tdata_o,
    output logic                             m_tlast_o,
    input  logic                             m_tready_i,
    output logic [PAYLOAD_WIDTH-1:0]         payload_bytes_o,
    output logic [GW-1:0]                    grant_o,
    output logic                             busy_o,
    output logic                             len_err_o
);

    localparam int GCW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GCW-1:0] GAP_LAST =
        GCW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam eth_tx_arb_state_t POST_PKT = (IFG_CYCLES == 0) ? IDLE : GAP;

    eth_tx_arb_state_t        state, state_d;
    logic [GW-1:0]            last_grant, sel;
    logic                     any_req;
    logic [PAYLOAD_WIDTH-1:0] sel_len, beat_cnt;
    logic [GCW-1:0]           gap_cnt;
    logic                     last_beat, hs, err_d;

    rr_arbiter #(
        .NUM_SRC(NUM_SRC)
    ) u_rr (
        .req       (s_tvalid_i),
        .last_grant(last_grant),
        .grant     (sel),
        .any_req   (any_req)
    );

    assign sel_len   = s_payload_bytes_i[int'(sel)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    assign last_beat = (beat_cnt == payload_bytes_o - PAYLOAD_WIDTH'(1));
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d    = state;
        s_tready_o = '0;
        m_tvalid_o = 1'b0;
        m_tlast_o  = 1'b0;
        m_tdata_o  = s_tdata_i[int'(grant_o)*DATA_WIDTH +: DATA_WIDTH];
        hs         = 1'b0;
        err_d      = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    // A zero-length declaration cannot be framed; discard it.
                    if (sel_len == '0) begin
                        state_d = DRAIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = XFER;
                    end
                end
            end
            XFER: begin
                m_tvalid_o          = s_tvalid_i[grant_o];
                s_tready_o[grant_o] = m_tready_i;
                m_tlast_o           = last_beat | s_tlast_i[grant_o];
                hs                  = m_tvalid_o & m_tready_i;
                if (hs) begin
                    if (last_beat && s_tlast_i[grant_o]) begin
                        state_d = POST_PKT;
                    end else if (last_beat) begin
                        state_d = DRAIN;
                        err_d   = 1'b1;
                    end else if (s_tlast_i[grant_o]) begin
                        state_d = POST_PKT;
                        err_d   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                s_tready_o[grant_o] = 1'b1;
                if (s_tvalid_i[grant_o] && s_tlast_i[grant_o])
                    state_d = POST_PKT;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_o         <= '0;
            last_grant      <= GW'(NUM_SRC - 1);
            payload_bytes_o <= '0;
            beat_cnt        <= '0;
            gap_cnt         <= '0;
            len_err_o       <= 1'b0;
        end else begin
            len_err_o <= err_d;
            if (state == IDLE && any_req) begin
                grant_o         <= sel;
                last_grant      <= sel;
                payload_bytes_o <= sel_len;
                beat_cnt        <= '0;
            end else if (hs) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state != GAP) gap_cnt <= '0;
            else              gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: queue-level round-robin model,
// directed length/backpressure/reset cases and randomized traffic.
module tb_eth_tx_arbiter;

    localparam int NS  = 4;
    localparam int DW  = 8;
    localparam int PW  = 11;
    localparam int IFG = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS-1:0]   s_tvalid, s_tlast, s_tready;
    logic [NS*DW-1:0] s_tdata;
    logic [NS*PW-1:0] s_len;
    logic            m_tvalid, m_tlast, m_tready, busy, len_err;
    logic [DW-1:0]   m_tdata;
    logic [PW-1:0]   pbytes;
    logic [1:0]      grant;

    always #5 clk = ~clk;

    eth_tx_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW), .IFG_CYCLES(IFG)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_tvalid_i(s_tvalid), .s_tdata_i(s_tdata), .s_tlast_i(s_tlast),
        .s_tready_o(s_tready), .s_payload_bytes_i(s_len),
        .m_tvalid_o(m_tvalid), .m_tdata_o(m_tdata), .m_tlast_o(m_tlast),
        .m_tready_i(m_tready), .payload_bytes_o(pbytes), .grant_o(grant),
        .busy_o(busy), .len_err_o(len_err)
    );

    typedef struct packed {logic [7:0] d; logic l;} beat_t;
    typedef struct packed {logic [1:0] s; logic [7:0] d; logic l;} exp_t;

    beat_t sq[NS][$];
    int    sl[NS][$];
    bit    started[NS];
    beat_t mq[NS][$];
    int    ml[NS][$];
    int    mn[NS][$];
    exp_t  expq[$];
    int    tl_src[$];

    int n_checks = 0, n_fail = 0;
    int exp_err = 0, err_seen = 0, hs_cnt = 0, cyc = 0;
    int t_last = 0, t_idle = 0, min_gap = 1000000;
    int pred_ptr = NS - 1;
    int rdy_mode = 0;
    bit bubbles = 0, after_last = 0, prev_busy = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int len, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.d = 8'($urandom);
            b.l = (k == n - 1);
            sq[s].push_back(b);
            mq[s].push_back(b);
        end
        sl[s].push_back(len);
        ml[s].push_back(len);
        mn[s].push_back(n);
    endtask

    // Round-robin over sources with queued packets; emitted beats follow
    // min(declared, sent), and any disagreement costs one error pulse.
    task automatic predict();
        int s, len, n, m;
        beat_t b;
        exp_t e;
        while (1) begin
            s = -1;
            for (int i = 1; i <= NS; i++) begin
                int c;
                c = (pred_ptr + i) % NS;
                if (s < 0 && ml[c].size() > 0) s = c;
            end
            if (s < 0) break;
            len = ml[s].pop_front();
            n   = mn[s].pop_front();
            m   = (len == 0) ? 0 : ((n < len) ? n : len);
            for (int k = 0; k < n; k++) begin
                b = mq[s].pop_front();
                if (k < m) begin
                    e.s = 2'(s);
                    e.d = b.d;
                    e.l = (k == m - 1);
                    expq.push_back(e);
                end
            end
            if (len != n) exp_err++;
            pred_ptr = s;
        end
    endtask

    function automatic bit all_empty();
        bit r;
        r = 1'b1;
        for (int k = 0; k < NS; k++)
            if (sq[k].size() > 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(all_empty() && !busy) && cnt < budget);
        @(negedge clk);
        check({name, "_done"}, 64'(cnt < budget), 64'd1);
        check({name, "_exp_left"}, 64'(expq.size()), 64'd0);
        check({name, "_len_err_cnt"}, 64'(err_seen), 64'(exp_err));
    endtask

    // Source drivers: pop accepted beats, present the next ones.
    initial begin : drv
        bit hs[NS];
        forever begin
            @(negedge clk);
            for (int k = 0; k < NS; k++)
                hs[k] = s_tvalid[k] & s_tready[k];
            @(posedge clk);
            #1;
            for (int k = 0; k < NS; k++) begin
                if (hs[k] && !rst && sq[k].size() > 0) begin
                    beat_t b;
                    b = sq[k].pop_front();
                    started[k] = 1'b1;
                    if (b.l) begin
                        void'(sl[k].pop_front());
                        started[k] = 1'b0;
                    end
                end
            end
            for (int k = 0; k < NS; k++) begin
                if (sq[k].size() > 0) begin
                    s_tvalid[k] = !(bubbles && started[k] &&
                                    $urandom_range(0, 3) == 0);
                    s_tdata[k*DW +: DW] = sq[k][0].d;
                    s_tlast[k] = sq[k][0].l;
                    s_len[k*PW +: PW] = PW'(sl[k][0]);
                end else begin
                    s_tvalid[k] = 1'b0;
                    s_tdata[k*DW +: DW] = '0;
                    s_tlast[k] = 1'b0;
                    s_len[k*PW +: PW] = '0;
                end
            end
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (len_err === 1'b1) err_seen++;
            if (prev_busy && !busy) t_idle = cyc;
            prev_busy = busy;
            if (m_tvalid === 1'b1 && expq.size() > 0) begin
                e = expq[0];
                check("s_tready_mirror", 64'(s_tready),
                      64'(m_tready ? (4'b1 << e.s) : 4'b0));
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                hs_cnt++;
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h expected none",
                             m_tdata);
                end else begin
                    e = expq.pop_front();
                    check("m_tdata", 64'(m_tdata), 64'(e.d));
                    check("m_tlast", 64'(m_tlast), 64'(e.l));
                    check("grant", 64'(grant), 64'(e.s));
                end
                if (after_last) begin
                    if (cyc - t_last < min_gap) min_gap = cyc - t_last;
                    after_last = 1'b0;
                end
                if (m_tlast) begin
                    t_last = cyc;
                    after_last = 1'b1;
                    tl_src.push_back(int'(grant));
                end
            end
        end
    end

    initial begin : main
        int c;
        int order[6];
        order = '{0, 2, 3, 0, 2, 3};
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_len = '0;
        m_tready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_tlast), 64'd0);
        check("rst_payload", 64'(pbytes), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // contention: 0,2,3 continuously requesting
        tl_src.delete();
        min_gap = 1000000;
        for (int r = 0; r < 2; r++) begin
            add_pkt(0, 10, 10);
            add_pkt(2, 10, 10);
            add_pkt(3, 10, 10);
        end
        predict();
        wait_done("contention", 3000);
        check("contention_pkts", 64'(tl_src.size()), 64'd6);
        for (int i = 0; i < 6 && i < tl_src.size(); i++)
            check("contention_order", 64'(tl_src[i]), 64'(order[i]));
        check("contention_gap", 64'(min_gap), 64'(IFG + 2));

        // single source, request-to-valid latency and IFG length
        @(posedge clk);
        #2;
        add_pkt(1, 64, 64);
        predict();
        @(posedge clk);
        @(negedge clk);
        check("latency_idle_valid", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        check("latency_grant", 64'(grant), 64'd1);
        check("latency_valid", 64'(m_tvalid), 64'd1);
        check("latency_payload", 64'(pbytes), 64'd64);
        wait_done("single", 2000);
        check("single_gap_busy", 64'(t_idle - t_last), 64'(IFG + 1));

        // backpressure
        rdy_mode = 1;
        hs_cnt = 0;
        add_pkt(2, 16, 16);
        predict();
        wait_done("backpressure", 2000);
        check("backpressure_hs", 64'(hs_cnt), 64'd16);
        rdy_mode = 0;

        // long, short, zero-length
        add_pkt(3, 8, 11);
        predict();
        wait_done("long", 2000);
        add_pkt(0, 8, 5);
        predict();
        wait_done("short", 2000);
        hs_cnt = 0;
        add_pkt(2, 0, 3);
        predict();
        wait_done("zero", 2000);
        check("zero_no_output", 64'(hs_cnt), 64'd0);

        // randomized traffic
        bubbles = 1'b1;
        rdy_mode = 2;
        for (int r = 0; r < 8; r++) begin
            int tot;
            tot = 0;
            for (int s = 0; s < NS; s++) begin
                int np;
                np = $urandom_range(0, 2);
                if (r % NS == s && np == 0) np = 1;
                for (int p = 0; p < np; p++) begin
                    int len, n;
                    n = $urandom_range(1, 20);
                    case ($urandom_range(0, 9))
                        0:       len = 0;
                        1, 2:    len = $urandom_range(1, 20);
                        default: len = n;
                    endcase
                    add_pkt(s, len, n);
                    tot++;
                end
            end
            predict();
            wait_done("random", 5000);
        end
        bubbles = 1'b0;
        rdy_mode = 0;

        // async reset mid-packet
        hs_cnt = 0;
        add_pkt(2, 40, 40);
        predict();
        c = 0;
        while (hs_cnt < 20 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("reset_reach_beat20", 64'(hs_cnt >= 20), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_s_tready", 64'(s_tready), 64'd0);
        check("async_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        for (int k = 0; k < NS; k++) begin
            sq[k].delete();
            sl[k].delete();
            started[k] = 1'b0;
        end
        expq.delete();
        pred_ptr = NS - 1;
        @(negedge clk);
        check("async_rst_grant", 64'(grant), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tl_src.delete();
        add_pkt(2, 12, 12);
        add_pkt(0, 12, 12);
        predict();
        wait_done("post_reset", 2000);
        check("post_reset_pkts", 64'(tl_src.size()), 64'd2);
        if (tl_src.size() >= 2) begin
            check("post_reset_first", 64'(tl_src[0]), 64'd0);
            check("post_reset_second", 64'(tl_src[1]), 64'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
